// File: rtl/axis_bridge_pkg.sv
// Shared definitions for the Galapagos AXI-Stream bridge egress path.
package axis_bridge_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    localparam int PKT_CNT_W = 16;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer: a main register driving the output and a skid register
// that catches the single beat in flight when the registered ready drops.
module axis_skid_buffer #(
    parameter int WIDTH = 19
) (
    input  logic             i_clk,
    input  logic             i_aresetn,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_payload,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_payload
);
    import axis_bridge_pkg::*;

    skid_state_e      state_reg, state_next;
    logic [WIDTH-1:0] main_reg, main_next;
    logic [WIDTH-1:0] skid_reg, skid_next;
    logic             ready_reg, ready_next;
    logic             acc, snd;

    assign acc = i_in_valid & ready_reg;
    assign snd = (state_reg != ST_EMPTY) & i_out_ready;

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state_reg <= ST_EMPTY;
            main_reg  <= '0;
            skid_reg  <= '0;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            main_reg  <= main_next;
            skid_reg  <= skid_next;
            ready_reg <= ready_next;
        end
    end

    // The main register only moves when it is empty or being sent, which keeps
    // the output stable under backpressure.
    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (acc) begin
                    main_next  = i_in_payload;
                    state_next = ST_ONE;
                end
            end
            ST_ONE: begin
                if (acc && snd) begin
                    main_next = i_in_payload;
                end else if (acc) begin
                    skid_next  = i_in_payload;
                    state_next = ST_FULL;
                end else if (snd) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (snd) begin
                    main_next  = skid_reg;
                    state_next = ST_ONE;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
        ready_next = (state_next != ST_FULL);
    end

    always_comb begin
        o_out_valid   = (state_reg != ST_EMPTY);
        o_out_payload = main_reg;
        o_in_ready    = ready_reg;
    end

endmodule

// File: rtl/axi_stream_write_extended.sv
// AXI-Stream transmitter: skid-buffered beats with a per-packet beat limiter
// that forces TLAST, a completed-packet counter and constant TDEST/TID.
module axi_stream_write_extended #(
    parameter int BUS_WIDTH = 16,
    parameter int TDEST     = 1,
    parameter int TID       = 0,
    parameter int MAX_BEATS = 256
) (
    input  logic                   i_clk,
    input  logic                   i_aresetn,
    input  logic                   i_input_valid,
    output logic                   o_input_ready,
    input  logic [BUS_WIDTH-1:0]   i_data,
    input  logic [BUS_WIDTH/8-1:0] i_tkeep,
    input  logic                   i_tlast,
    output logic                   o_tvalid,
    input  logic                   i_tready,
    output logic [BUS_WIDTH-1:0]   o_tdata,
    output logic [BUS_WIDTH/8-1:0] o_tkeep,
    output logic                   o_tlast,
    output logic [7:0]             o_tdest,
    output logic [7:0]             o_tid,
    output logic [15:0]            o_packet_count
);
    import axis_bridge_pkg::*;

    localparam int KEEP_W = BUS_WIDTH / 8;
    localparam int PAY_W  = BUS_WIDTH + KEEP_W + 1;
    localparam int CNT_W  = $clog2(MAX_BEATS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_BEATS - 1);

    logic [CNT_W-1:0]     beat_cnt_reg, beat_cnt_next;
    logic [PKT_CNT_W-1:0] pkt_cnt_reg, pkt_cnt_next;
    logic [PAY_W-1:0]     in_payload, out_payload;
    logic                 in_ready, out_valid;
    logic                 acc, snd, stored_last;

    assign acc         = i_input_valid & in_ready;
    assign snd         = out_valid & i_tready;
    assign stored_last = i_tlast | (beat_cnt_reg == LAST_IDX);
    assign in_payload  = {i_data, i_tkeep, stored_last};

    axis_skid_buffer #(
        .WIDTH(PAY_W)
    ) u_skid (
        .i_clk        (i_clk),
        .i_aresetn    (i_aresetn),
        .i_in_valid   (i_input_valid),
        .o_in_ready   (in_ready),
        .i_in_payload (in_payload),
        .o_out_valid  (out_valid),
        .i_out_ready  (i_tready),
        .o_out_payload(out_payload)
    );

    always_comb begin
        beat_cnt_next = beat_cnt_reg;
        pkt_cnt_next  = pkt_cnt_reg;
        if (acc) begin
            beat_cnt_next = stored_last ? '0 : beat_cnt_reg + CNT_W'(1);
        end
        if (snd && out_payload[0]) begin
            pkt_cnt_next = pkt_cnt_reg + PKT_CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            beat_cnt_reg <= '0;
            pkt_cnt_reg  <= '0;
        end else begin
            beat_cnt_reg <= beat_cnt_next;
            pkt_cnt_reg  <= pkt_cnt_next;
        end
    end

    assign o_input_ready           = in_ready;
    assign o_tvalid                = out_valid;
    assign {o_tdata, o_tkeep, o_tlast} = out_payload;
    assign o_packet_count          = pkt_cnt_reg;
    assign o_tdest                 = 8'(TDEST);
    assign o_tid                   = 8'(TID);

endmodule

// File: tb/tb_axi_stream_write_extended.sv
// Directed and randomised-ready checks of the AXI-Stream transmitter; a second
// instance with MAX_BEATS=4 exercises the forced-TLAST limiter.
module tb_axi_stream_write_extended;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic [1:0]  in_keep = '0;
    logic        in_tlast = 1'b0;
    logic        tready = 1'b0;

    logic        in_ready, tvalid, tlast;
    logic [15:0] tdata, pcnt;
    logic [1:0]  tkeep;
    logic [7:0]  tdest, tid;

    logic        in_ready4, tvalid4, tlast4;
    logic [15:0] tdata4, pcnt4;
    logic [1:0]  tkeep4;
    logic [7:0]  tdest4, tid4;

    int checks = 0;
    int errors = 0;
    int exp_pkts = 0;

    always #5 clk = ~clk;

    axi_stream_write_extended dut (
        .i_clk(clk), .i_aresetn(rstn),
        .i_input_valid(in_valid), .o_input_ready(in_ready),
        .i_data(in_data), .i_tkeep(in_keep), .i_tlast(in_tlast),
        .o_tvalid(tvalid), .i_tready(tready),
        .o_tdata(tdata), .o_tkeep(tkeep), .o_tlast(tlast),
        .o_tdest(tdest), .o_tid(tid), .o_packet_count(pcnt)
    );

    axi_stream_write_extended #(.MAX_BEATS(4)) dut4 (
        .i_clk(clk), .i_aresetn(rstn),
        .i_input_valid(in_valid), .o_input_ready(in_ready4),
        .i_data(in_data), .i_tkeep(in_keep), .i_tlast(in_tlast),
        .o_tvalid(tvalid4), .i_tready(tready),
        .o_tdata(tdata4), .o_tkeep(tkeep4), .o_tlast(tlast4),
        .o_tdest(tdest4), .o_tid(tid4), .o_packet_count(pcnt4)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        in_valid = 1'b0;
        rstn = 1'b0;
        step;
        step;
        rstn = 1'b1;
        step;
        exp_pkts = 0;
    endtask

    task automatic test_reset;
        in_valid = 1'b0; tready = 1'b0; rstn = 1'b0;
        step; step;
        rstn = 1'b1;
        step;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
        in_valid = 1'b1; in_data = 16'h1111; in_keep = 2'b11; in_tlast = 1'b0;
        step;
        in_data = 16'h2222;
        step;
        in_valid = 1'b0;
        checks++;
        if (tvalid !== 1'b1 || in_ready !== 1'b0 || tdata !== 16'h1111) begin
            errors++; $display("FAIL reset_prefill: tvalid=%b ready=%b tdata=%h expected 1 0 1111", tvalid, in_ready, tdata);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({tvalid, in_ready, tdata, tkeep, tlast, pcnt} !== 36'd0) begin
            errors++; $display("FAIL reset_async_outputs: tvalid=%b ready=%b tdata=%h tkeep=%b tlast=%b pcnt=%h expected all zero", tvalid, in_ready, tdata, tkeep, tlast, pcnt);
        end
        checks++;
        if (tdest !== 8'd1 || tid !== 8'd0) begin errors++; $display("FAIL reset_tdest_tid: tdest=%h tid=%h expected 01 00", tdest, tid); end
        step;
        rstn = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_before_edge: got %b expected 0", in_ready); end
        step;
        checks++;
        if (in_ready !== 1'b1 || tvalid !== 1'b0) begin
            errors++; $display("FAIL reset_first_edge: ready=%b tvalid=%b expected 1 0", in_ready, tvalid);
        end
        in_valid = 1'b1; in_data = 16'hA5A5; in_keep = 2'b11; in_tlast = 1'b1;
        step;
        in_valid = 1'b0;
        checks++;
        if (tvalid !== 1'b1 || tdata !== 16'hA5A5 || tlast !== 1'b1) begin
            errors++; $display("FAIL reset_first_beat: tvalid=%b tdata=%h tlast=%b expected 1 a5a5 1", tvalid, tdata, tlast);
        end
        tready = 1'b1;
        step;
        checks++;
        if (tvalid !== 1'b0 || pcnt !== 16'd1) begin
            errors++; $display("FAIL reset_first_send: tvalid=%b pcnt=%h expected 0 0001", tvalid, pcnt);
        end
        exp_pkts = 1;
        $display("reset: in-flight beats discarded, A5A5 delivered");
    endtask

    task automatic test_streaming;
        tready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready beat %0d: got %b expected 1", i, in_ready); end
            in_valid = 1'b1; in_data = 16'(i); in_keep = 2'b11; in_tlast = (i == 8);
            step;
            checks++;
            if (tvalid !== 1'b1 || tdata !== 16'(i) || tlast !== (i == 8)) begin
                errors++; $display("FAIL stream_beat %0d: tvalid=%b tdata=%h tlast=%b expected 1 %h %b", i, tvalid, tdata, tlast, 16'(i), (i == 8));
            end
            $display("stream: beat %h tlast=%b", tdata, tlast);
        end
        in_valid = 1'b0; in_tlast = 1'b0;
        step;
        exp_pkts++;
        checks++;
        if (tvalid !== 1'b0 || pcnt !== 16'(exp_pkts)) begin
            errors++; $display("FAIL stream_pkt_count: tvalid=%b pcnt=%h expected 0 %h", tvalid, pcnt, 16'(exp_pkts));
        end
    endtask

    task automatic test_backpressure;
        tready = 1'b0;
        in_valid = 1'b1; in_data = 16'h0011; in_keep = 2'b01; in_tlast = 1'b0;
        step;
        checks++;
        if (tvalid !== 1'b1 || tdata !== 16'h0011 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_one: tvalid=%b tdata=%h ready=%b expected 1 0011 1", tvalid, tdata, in_ready);
        end
        in_data = 16'h0022; in_keep = 2'b10; in_tlast = 1'b1;
        step;
        checks++;
        if (in_ready !== 1'b0 || tdata !== 16'h0011 || tkeep !== 2'b01) begin
            errors++; $display("FAIL bp_full: ready=%b tdata=%h tkeep=%b expected 0 0011 01", in_ready, tdata, tkeep);
        end
        in_data = 16'h0033; in_tlast = 1'b0;
        step;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || tvalid !== 1'b1 || tdata !== 16'h0011) begin
            errors++; $display("FAIL bp_hold: ready=%b tvalid=%b tdata=%h expected 0 1 0011", in_ready, tvalid, tdata);
        end
        tready = 1'b1;
        step;
        checks++;
        if (tvalid !== 1'b1 || tdata !== 16'h0022 || tkeep !== 2'b10 || tlast !== 1'b1 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_drain: tvalid=%b tdata=%h tkeep=%b tlast=%b ready=%b expected 1 0022 10 1 1", tvalid, tdata, tkeep, tlast, in_ready);
        end
        $display("backpressure: drained skid beat %h", tdata);
        step;
        exp_pkts++;
        checks++;
        if (tvalid !== 1'b0 || pcnt !== 16'(exp_pkts)) begin
            errors++; $display("FAIL bp_empty: tvalid=%b pcnt=%h expected 0 %h", tvalid, pcnt, 16'(exp_pkts));
        end
    endtask

    task automatic test_random;
        logic [18:0] q[$];
        logic [18:0] exp_b;
        logic [15:0] held_data;
        logic [1:0]  held_keep;
        logic        held_last;
        logic        stall;
        logic        sl;
        logic [7:0]  mcnt;
        int issued, recv, budget;
        issued = 0; recv = 0; budget = 0; stall = 1'b0; mcnt = '0;
        held_data = '0; held_keep = '0; held_last = 1'b0;
        while (recv < 1000 && budget < 20000) begin
            tready   = 1'($urandom_range(0, 1));
            in_valid = (issued < 1000) && ($urandom_range(0, 3) != 0);
            in_data  = 16'($urandom);
            in_keep  = 2'($urandom);
            in_tlast = (issued == 999) || ($urandom_range(0, 7) == 0);
            if (stall) begin
                checks++;
                if (tvalid !== 1'b1 || tdata !== held_data || tkeep !== held_keep || tlast !== held_last) begin
                    errors++; $display("FAIL rand_stability: tvalid=%b tdata=%h tkeep=%b tlast=%b expected 1 %h %b %b", tvalid, tdata, tkeep, tlast, held_data, held_keep, held_last);
                end
            end
            if (tvalid && tready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_extra_beat: got %h expected no beat", tdata);
                end else begin
                    exp_b = q.pop_front();
                    if ({tdata, tkeep, tlast} !== exp_b) begin
                        errors++; $display("FAIL rand_beat %0d: got %h expected %h", recv, {tdata, tkeep, tlast}, exp_b);
                    end
                    if (exp_b[0]) exp_pkts++;
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                sl = in_tlast | (mcnt == 8'hFF);
                q.push_back({in_data, in_keep, sl});
                mcnt = sl ? 8'd0 : mcnt + 8'd1;
                issued++;
            end
            stall = tvalid && !tready;
            held_data = tdata; held_keep = tkeep; held_last = tlast;
            step;
            budget++;
        end
        in_valid = 1'b0; in_tlast = 1'b0;
        checks++;
        if (recv < 1000) begin errors++; $display("FAIL rand_timeout: received %0d expected 1000", recv); end
        checks++;
        if (pcnt !== 16'(exp_pkts)) begin errors++; $display("FAIL rand_pkt_count: got %h expected %h", pcnt, 16'(exp_pkts)); end
        $display("random: %0d beats received, %0d packets", recv, exp_pkts);
    endtask

    task automatic test_forced_last;
        do_reset;
        tready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1; in_data = 16'(i); in_keep = 2'b11; in_tlast = 1'b0;
            step;
            checks++;
            if (tvalid4 !== 1'b1 || tdata4 !== 16'(i) || tlast4 !== (i == 4 || i == 8)) begin
                errors++; $display("FAIL forced_last beat %0d: tvalid=%b tdata=%h tlast=%b expected 1 %h %b", i, tvalid4, tdata4, tlast4, 16'(i), (i == 4 || i == 8));
            end
            if (i == 4) begin
                checks++;
                if (tlast !== 1'b0) begin errors++; $display("FAIL forced_last_default_limit: tlast=%b expected 0", tlast); end
            end
            $display("forced: beat %h tlast=%b", tdata4, tlast4);
        end
        in_valid = 1'b0;
        step;
        checks++;
        if (pcnt4 !== 16'd2) begin errors++; $display("FAIL forced_pkt_count: got %h expected 0002", pcnt4); end
    endtask

    task automatic test_counter_wrap;
        do_reset;
        tready = 1'b1;
        in_keep = 2'b11; in_tlast = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            in_valid = 1'b1; in_data = 16'(i);
            step;
        end
        in_valid = 1'b0;
        checks++;
        if (pcnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff: got %h expected ffff", pcnt); end
        step;
        checks++;
        if (pcnt !== 16'h0000 || tvalid !== 1'b0) begin
            errors++; $display("FAIL wrap_zero: pcnt=%h tvalid=%b expected 0000 0", pcnt, tvalid);
        end
        $display("wrap: packet counter %h after 65536 packets", pcnt);
    endtask

    initial begin
        test_reset;
        test_streaming;
        test_backpressure;
        test_random;
        test_forced_last;
        test_counter_wrap;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_stream_write_extended.md
# axi_stream_write_extended

AXI-Stream transmitter for the Galapagos bridge. It accepts single beats from a local producer over a valid/ready handshake and drives them onto an AXI-Stream master port, including TKEEP, TLAST, TDEST and TID. A two-entry skid buffer allows full throughput with registered outputs, and a per-packet beat limiter forces TLAST on over-long packets. It sits at the bridge egress, opposite the stream reader that consumes TDEST-addressed beats.

## Interface
- BUS_WIDTH, 16: TDATA width in bits; a multiple of 8.
- TDEST, 1: constant driven on o_tdest, 8 bits.
- TID, 0: constant driven on o_tid, 8 bits.
- MAX_BEATS, 256: maximum number of beats per packet, ≥2; TLAST is forced on beat MAX_BEATS.

Ports:
- i_clk  in  1  the single clock; everything is rising-edge.
- i_aresetn  in  1  reset, asynchronous, active-low.
- i_input_valid  in  1  producer beat valid.
- o_input_ready  out  1  beat accepted when valid & ready at an edge.
- i_data  in  BUS_WIDTH  beat data.
- i_tkeep  in  BUS_WIDTH/8  byte qualifiers.
- i_tlast  in  1  last beat of packet.
- o_tvalid  out  1  AXIS valid.
- i_tready  in  1  AXIS ready.
- o_tdata  out  BUS_WIDTH  AXIS data.
- o_tkeep  out  BUS_WIDTH/8  AXIS keep.
- o_tlast  out  1  AXIS last.
- o_tdest  out  8  equals TDEST at all times.
- o_tid  out  8  equals TID at all times.
- o_packet_count  out  16  number of TLAST beats completed on AXIS; wraps at 16 bits.

## Operation
- Storage consists of a main register (drives AXIS outputs) and a skid register. Each holds data, keep and last.
- States:
  - EMPTY: o_tvalid=0.
  - ONE: main register valid.
  - FULL: main and skid registers valid.
- o_input_ready is registered and equals (next state != FULL).
- Transitions (acc = input handshake, snd = o_tvalid & i_tready):
  - EMPTY, acc → ONE; the beat loads into main.
  - ONE, acc & snd → ONE; the new beat loads into main.
  - ONE, acc & !snd → FULL; the beat loads into skid.
  - ONE, !acc & snd → EMPTY.
  - FULL, snd → ONE; skid moves to main. No acc is possible in FULL because ready is low.
  - In all other cases the state and registers hold.
- The main register and o_tvalid do not change while o_tvalid=1 and i_tready=0 (AXIS stability rule).
- Beat limiter:
  - The counter has width $clog2(MAX_BEATS) and counts accepted beats in the current packet.
  - On acc, stored last = i_tlast | (counter == MAX_BEATS-1).
  - The counter clears when the stored last is 1; otherwise it increments.
- o_packet_count increments on snd & o_tlast and wraps from 0xFFFF to 0.
- Reset, async assert at any point, including mid-packet or in FULL:
  - state=EMPTY, o_tvalid=0, o_input_ready=0.
  - o_tdata=0, o_tkeep=0, o_tlast=0.
  - beat counter=0, o_packet_count=0.
  - In-flight beats are discarded.
  - o_input_ready rises on the first edge after deassertion.

## Timing
- Latency is 1 cycle: a beat accepted at edge N appears on AXIS with o_tvalid=1 after edge N, if it lands in main.
- A beat that lands in skid appears after the edge where the main beat is sent.
- Throughput is 1 beat/cycle with i_tready held high.
- o_input_ready drops the cycle after FULL is entered. It rises after the edge where FULL drains to ONE.
- The skid entry absorbs the one beat in flight when ready drops.
- All outputs are registered. There is no combinational path from i_tready to o_input_ready.

## Structure
- Shared package axis_bridge_pkg holds:
  - state encoding constants ST_EMPTY, ST_ONE, ST_FULL;
  - the packet counter width constant PKT_CNT_W=16.
- One natural sub-module: axis_skid_buffer, the two-entry register pair and its FSM, parameterised on payload width (BUS_WIDTH + BUS_WIDTH/8 + 1).
- The top level holds the beat limiter, the packet counter and the constant TDEST/TID drive.

## Test plan
- Reset: assert i_aresetn=0 mid-stream with 2 beats buffered → all outputs 0 and o_tdest=1 at once. After release, the first beat 0xA5A5 appears 1 cycle after acceptance.
- Streaming: 8 beats 0x0001..0x0008, last on beat 8, i_tready=1 → one beat per cycle, in order, o_tlast only on 0x0008, o_packet_count=1.
- Backpressure: i_tready=0 while sending beats 0x0011, 0x0022 → FULL, o_input_ready=0, o_tdata holds 0x0011. Raise i_tready → 0x0011 then 0x0022, no loss or duplication.
- Random i_tready (50%) over 1000 beats → output sequence equals input sequence, and AXIS stability holds whenever o_tvalid=1 & i_tready=0.
- Forced last: MAX_BEATS=4, 10 beats with i_tlast=0 → o_tlast on beats 4 and 8, o_packet_count=2.
- Counter wrap: preload 0xFFFF packets via 65536 single-beat packets → o_packet_count reads 0x0000.
